// File: rtl/dc_load_stage_pkg.sv
// Shared definitions for the data-cache load stage: bus widths and field positions,
// stall vector indices, memory-op encodings and FSM state encodings.
package dc_load_stage_pkg;

    localparam int EX_TO_DC_WD_DFLT = 152;
    localparam int DC_TO_WB_WD_DFLT = 136;
    localparam int DC_TO_RF_WD_DFLT = 105;

    localparam int  STALL_DC = 4;
    localparam int  STALL_WB = 5;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Field positions inside ex_to_dc_bus
    localparam int EX_IS_LOAD  = 151;
    localparam int EX_MOP_HI   = 150;
    localparam int EX_MOP_LO   = 143;
    localparam int EX_HILO_HI  = 142;
    localparam int EX_HILO_LO  = 77;
    localparam int EX_PC_HI    = 76;
    localparam int EX_PC_LO    = 45;
    localparam int EX_RAM_HI   = 44;
    localparam int EX_RAM_LO   = 39;
    localparam int EX_SEL_RF   = 38;
    localparam int EX_RF_WE    = 37;
    localparam int EX_WADDR_HI = 36;
    localparam int EX_WADDR_LO = 32;

    // One-hot mem_op, MSB first: lb, lbu, lh, lhu, lw, sb, sh, sw
    localparam logic [7:0] MOP_LB  = 8'b1000_0000;
    localparam logic [7:0] MOP_LBU = 8'b0100_0000;
    localparam logic [7:0] MOP_LH  = 8'b0010_0000;
    localparam logic [7:0] MOP_LHU = 8'b0001_0000;
    localparam logic [7:0] MOP_LW  = 8'b0000_1000;
    localparam logic [7:0] MOP_SB  = 8'b0000_0100;
    localparam logic [7:0] MOP_SH  = 8'b0000_0010;
    localparam logic [7:0] MOP_SW  = 8'b0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dc_state_e;

endpackage

// File: rtl/dc_load_stage_if.sv
// Load-data return channel. data_sram_rvalid is a one-cycle pulse qualifying
// data_sram_rdata; there is no ready, the stage samples it whenever it is waiting.
interface dc_load_stage_if;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;

    modport master (output data_sram_rdata, output data_sram_rvalid);
    modport slave  (input  data_sram_rdata, input  data_sram_rvalid);
endinterface

// File: rtl/dc_load_stage_load_align.sv
// Combinational load alignment: picks the byte/half/word addressed by addr and extends it.
module load_align
    import dc_load_stage_pkg::*;
(
    input  logic [7:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfword loads ignore addr[0]
        half_sel = addr[1] ? word[31:16] : word[15:0];

        data = '0;
        case (mem_op)
            MOP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MOP_LBU: data = {24'b0, byte_sel};
            MOP_LH:  data = {{16{half_sel[15]}}, half_sel};
            MOP_LHU: data = {16'b0, half_sel};
            MOP_LW:  data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dc_load_stage.sv
// Data-cache load stage: pipeline register, load-wait FSM and result alignment.
// Optional load watchdog enabled by defining DC_LOAD_TIMEOUT_EN.
module dc_load_stage
    import dc_load_stage_pkg::*;
#(
    parameter int EX_TO_DC_WD = EX_TO_DC_WD_DFLT,
    parameter int DC_TO_WB_WD = DC_TO_WB_WD_DFLT,
    parameter int DC_TO_RF_WD = DC_TO_RF_WD_DFLT,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [5:0]             stall,
    output logic                   stallreq_for_dc,
    input  logic [EX_TO_DC_WD-1:0] ex_to_dc_bus,
    dc_load_stage_if.slave         sram,
    output logic [DC_TO_WB_WD-1:0] dc_to_wb_bus,
    output logic [DC_TO_RF_WD-1:0] dc_to_rf_bus,
    output logic                   dc_load_timeout,
    output dc_state_e              fsm_state
);

    logic [EX_TO_DC_WD-1:0] ex_r;
    logic [EX_TO_DC_WD-1:0] ex_next;
    logic                   reg_upd;
    logic [31:0]            load_buf;
    dc_state_e              state;
    logic                   is_load;
    logic                   use_rdata;
    logic [31:0]            load_word;
    logic [31:0]            align_data;
    logic [31:0]            rf_wdata;
    logic [31:0]            ex_result;

    // Register takes EX when this stage runs, a bubble when only WB runs, else holds
    assign reg_upd = (stall[STALL_DC] == NO_STOP) || (stall[STALL_WB] == NO_STOP);
    assign ex_next = (stall[STALL_DC] == NO_STOP) ? ex_to_dc_bus : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_r <= '0;
        end else if (reg_upd) begin
            ex_r <= ex_next;
        end
    end

    assign is_load   = ex_r[EX_IS_LOAD];
    assign ex_result = ex_r[31:0];
    // Returned data only counts while a load is still outstanding
    assign use_rdata = is_load && (state != ST_DONE) && sram.data_sram_rvalid;

`ifdef DC_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            load_buf <= '0;
`ifdef DC_LOAD_TIMEOUT_EN
            wait_cnt        <= '0;
            dc_load_timeout <= 1'b0;
`endif
        end else if (reg_upd) begin
            state <= ex_next[EX_IS_LOAD] ? ST_WAIT : ST_IDLE;
`ifdef DC_LOAD_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else if (use_rdata) begin
            state    <= ST_DONE;
            load_buf <= sram.data_sram_rdata;
        end
`ifdef DC_LOAD_TIMEOUT_EN
        else if (is_load && (state == ST_WAIT)) begin
            if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                state           <= ST_DONE;
                load_buf        <= '0;
                dc_load_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
`endif
    end

`ifndef DC_LOAD_TIMEOUT_EN
    assign dc_load_timeout = 1'b0;
`endif

    assign stallreq_for_dc = is_load && (state != ST_DONE) && !sram.data_sram_rvalid;
    assign load_word       = use_rdata ? sram.data_sram_rdata : load_buf;

    load_align u_align (
        .mem_op (ex_r[EX_MOP_HI:EX_MOP_LO]),
        .addr   (ex_result[1:0]),
        .word   (load_word),
        .data   (align_data)
    );

    assign rf_wdata = ex_r[EX_SEL_RF] ? align_data : ex_result;

    assign dc_to_wb_bus = {ex_r[EX_HILO_HI:EX_HILO_LO], ex_r[EX_PC_HI:EX_PC_LO],
                           ex_r[EX_RF_WE], ex_r[EX_WADDR_HI:EX_WADDR_LO], rf_wdata};
    assign dc_to_rf_bus = {stallreq_for_dc, ex_r[EX_HILO_HI:EX_HILO_LO],
                           ex_r[EX_RF_WE], ex_r[EX_WADDR_HI:EX_WADDR_LO], rf_wdata};
    assign fsm_state    = state;

    // RAM request fields were consumed by EX; they only ride along here
    logic unused_fields;
    assign unused_fields = ^{ex_r[EX_RAM_HI:EX_RAM_LO], (TIMEOUT_CYC != 0)};

endmodule

// File: tb/tb_dc_load_stage.sv
// Self-checking bench for dc_load_stage; the timeout scenario follows DC_LOAD_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_dc_load_stage;
    import dc_load_stage_pkg::*;

    localparam logic [7:0] OP_NONE = 8'h00;
    localparam logic [7:0] OP_LB   = 8'h80;
    localparam logic [7:0] OP_LBU  = 8'h40;
    localparam logic [7:0] OP_LH   = 8'h20;
    localparam logic [7:0] OP_LHU  = 8'h10;
    localparam logic [7:0] OP_LW   = 8'h08;
    localparam logic [7:0] OP_SW   = 8'h01;

    logic         clk = 1'b0;
    logic         resetn;
    logic [5:0]   stall_base;
    logic [5:0]   stall;
    logic [151:0] ex_to_dc_bus;
    logic         stallreq_for_dc;
    logic         dc_load_timeout;
    logic [135:0] dc_to_wb_bus;
    logic [104:0] dc_to_rf_bus;
    dc_state_e    fsm_state;

    dc_load_stage_if sram_if ();

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    // clock / reset
    always #5 clk = ~clk;

    // The bench plays stall controller: a pending load holds both DC and WB
    assign stall = stall_base | {stallreq_for_dc, stallreq_for_dc, 4'b0};

    dc_load_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .stallreq_for_dc (stallreq_for_dc),
        .ex_to_dc_bus    (ex_to_dc_bus),
        .sram            (sram_if.slave),
        .dc_to_wb_bus    (dc_to_wb_bus),
        .dc_to_rf_bus    (dc_to_rf_bus),
        .dc_load_timeout (dc_load_timeout),
        .fsm_state       (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [151:0] mk_op(input logic [7:0] mop, input logic [31:0] pc,
                                           input logic sel, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] res);
        logic ld;
        logic st;
        ld = |mop[7:3];
        st = |mop[2:0];
        return {ld, mop, {2'b10, pc, ~pc}, pc, ld | st, st, 4'hf, sel, we, waddr, res};
    endfunction

    // driver tasks
    task automatic send(input logic [151:0] bus);
        ex_to_dc_bus = bus;
        @(posedge clk); #1;
        ex_to_dc_bus = '0;
    endtask

    task automatic load_resp(input int n_wait, input logic [31:0] rdata, output int stalls);
        stalls = 0;
        for (int i = 0; i < n_wait; i++) begin
            @(negedge clk);
            if (stallreq_for_dc) stalls++;
            @(posedge clk); #1;
        end
        sram_if.data_sram_rdata  = rdata;
        sram_if.data_sram_rvalid = 1'b1;
        @(negedge clk);
        if (stallreq_for_dc) stalls++;
        @(posedge clk); #1;
        sram_if.data_sram_rvalid = 1'b0;
        sram_if.data_sram_rdata  = $urandom;
    endtask

    task automatic do_load(input logic [7:0] mop, input logic [31:0] addr, input logic [4:0] waddr,
                           input logic [31:0] rdata, input logic [31:0] exp_data, input int n_wait,
                           input string tag);
        int st;
        exp_q.push_back({waddr, exp_data});
        send(mk_op(mop, 32'h0000_1000 + addr, 1'b1, 1'b1, waddr, addr));
        load_resp(n_wait, rdata, st);
        check(tag, 64'(st), 64'(n_wait));
    endtask

    // scoreboard: a register write leaves the stage when it is valid and DC advances
    always @(negedge clk) begin
        if (resetn && dc_to_wb_bus[37] && (stall[STALL_DC] == NO_STOP)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("wb_write", 64'(dc_to_wb_bus[36:0]), 64'(mon_exp));
                check("rf_fwd",   64'(dc_to_rf_bus[36:0]), 64'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] lb_word;
    logic [31:0] lb_exp [4];
    logic [31:0] res;
    logic [4:0]  wa;
    int          st;
    bit          done;

    initial begin
        resetn                   = 1'b0;
        stall_base               = '0;
        ex_to_dc_bus             = '0;
        sram_if.data_sram_rvalid = 1'b0;
        sram_if.data_sram_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb",       64'(dc_to_wb_bus[63:0]), 64'd0);
        check("rst_rf",       64'(dc_to_rf_bus[63:0]), 64'd0);
        check("rst_stallreq", 64'(stallreq_for_dc), 64'd0);
        check("rst_timeout",  64'(dc_load_timeout), 64'd0);
        check("rst_state",    64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk); #1;
        resetn = 1'b1;

        // plain ALU results pass straight through
        for (int i = 0; i < 4; i++) begin
            res = $urandom;
            wa  = 5'($urandom_range(1, 31));
            exp_q.push_back({wa, res});
            send(mk_op(OP_NONE, 32'h0000_0040 + 32'(i * 4), 1'b0, 1'b1, wa, res));
        end
        @(negedge clk);
        check("alu_hilo", 64'(dc_to_wb_bus[135:70]), 64'({2'b10, 32'h0000_004C, ~32'h0000_004C}));
        check("alu_pc",   64'(dc_to_wb_bus[69:38]), 64'h4C);
        @(posedge clk); #1;

        // zero-wait word load
        do_load(OP_LW, 32'h100, 5'd2, 32'h1234_5678, 32'h1234_5678, 0, "lw_zero_wait_stalls");

        // byte loads with wait states
        do_load(OP_LB,  32'h203, 5'd3, 32'h80FF_0000, 32'hFFFF_FF80, 3, "lb_stalls");
        do_load(OP_LBU, 32'h203, 5'd4, 32'h80FF_0000, 32'h0000_0080, 3, "lbu_stalls");

        // every byte lane of one word
        lb_word   = 32'h11A2_33C4;
        lb_exp[0] = 32'hFFFF_FFC4;
        lb_exp[1] = 32'h0000_0033;
        lb_exp[2] = 32'hFFFF_FFA2;
        lb_exp[3] = 32'h0000_0011;
        for (int a = 0; a < 4; a++)
            do_load(OP_LB, 32'h500 + 32'(a), 5'd5, lb_word, lb_exp[a],
                    $urandom_range(0, 2), "lb_lane_stalls");

        // halfword loads; addr[0] does not move the half
        do_load(OP_LHU, 32'h302, 5'd6, 32'hBEEF_1234, 32'h0000_BEEF, 1, "lhu_stalls");
        do_load(OP_LH,  32'h302, 5'd6, 32'hBEEF_1234, 32'hFFFF_BEEF, 0, "lh_stalls");
        do_load(OP_LH,  32'h301, 5'd6, 32'h0000_8001, 32'hFFFF_8001, 2, "lh_odd_stalls");

        // data held in DONE while WB is stopped; extra rvalid pulses ignored
        exp_q.push_back({5'd7, 32'hA5A5_0F0F});
        send(mk_op(OP_LW, 32'h600, 1'b1, 1'b1, 5'd7, 32'h0000_0600));
        stall_base = 6'b110000;
        load_resp(1, 32'hA5A5_0F0F, st);
        check("done_hold_stalls", 64'(st), 64'd1);
        for (int i = 0; i < 4; i++) begin
            sram_if.data_sram_rdata  = 32'hDEAD_BEEF;
            sram_if.data_sram_rvalid = 1'b1;
            @(negedge clk);
            check("done_state",    64'(fsm_state), 64'(ST_DONE));
            check("done_stallreq", 64'(stallreq_for_dc), 64'd0);
            @(posedge clk); #1;
        end
        sram_if.data_sram_rvalid = 1'b0;
        @(negedge clk);
        check("done_buf_held", 64'(dc_to_wb_bus[31:0]), 64'hA5A5_0F0F);
        @(posedge clk); #1;
        stall_base = '0;
        @(posedge clk); #1;

        // bubble: DC stopped while WB runs
        ex_to_dc_bus = mk_op(OP_NONE, 32'h700, 1'b0, 1'b1, 5'd8, 32'h7777_7777);
        stall_base   = 6'b010000;
        @(posedge clk); #1;
        ex_to_dc_bus = '0;
        @(negedge clk);
        check("bubble_wb", 64'(dc_to_wb_bus[63:0]), 64'd0);
        @(posedge clk); #1;
        stall_base = '0;

        // hold: both stopped keeps the instruction in place
        exp_q.push_back({5'd9, 32'h5A5A_1234});
        send(mk_op(OP_NONE, 32'h704, 1'b0, 1'b1, 5'd9, 32'h5A5A_1234));
        stall_base = 6'b110000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_wb_data", 64'(dc_to_wb_bus[31:0]), 64'h5A5A_1234);
        end
        @(posedge clk); #1;
        stall_base = '0;
        @(posedge clk); #1;

        // store passes through; rvalid with no load registered is ignored
        send(mk_op(OP_SW, 32'h800, 1'b0, 1'b0, 5'd0, 32'h0000_0800));
        sram_if.data_sram_rdata  = 32'hFFFF_FFFF;
        sram_if.data_sram_rvalid = 1'b1;
        @(negedge clk);
        check("store_stallreq", 64'(stallreq_for_dc), 64'd0);
        check("store_pc",       64'(dc_to_wb_bus[69:38]), 64'h800);
        check("store_result",   64'(dc_to_wb_bus[31:0]), 64'h800);
        @(posedge clk); #1;
        sram_if.data_sram_rvalid = 1'b0;
        @(negedge clk);
        check("stray_idle", 64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk); #1;

        // reset in the middle of a wait abandons the load
        send(mk_op(OP_LW, 32'h900, 1'b1, 1'b1, 5'd10, 32'h0000_0900));
        @(negedge clk);
        check("wait_stallreq",     64'(stallreq_for_dc), 64'd1);
        check("wait_load_pending", 64'(dc_to_rf_bus[104]), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_state", 64'(fsm_state), 64'(ST_WAIT));
        #2;
        resetn = 1'b0;
        #1;
        check("arst_wb",       64'(dc_to_wb_bus[63:0]), 64'd0);
        check("arst_stallreq", 64'(stallreq_for_dc), 64'd0);
        check("arst_state",    64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk); #1;
        resetn = 1'b1;
        sram_if.data_sram_rdata  = 32'hCAFE_CAFE;
        sram_if.data_sram_rvalid = 1'b1;
        @(negedge clk);
        check("post_rst_stallreq", 64'(stallreq_for_dc), 64'd0);
        check("post_rst_wb",       64'(dc_to_wb_bus[63:0]), 64'd0);
        @(posedge clk); #1;
        sram_if.data_sram_rvalid = 1'b0;
        @(negedge clk);
        check("post_rst_state", 64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk); #1;

`ifdef DC_LOAD_TIMEOUT_EN
        // watchdog: no data ever returns
        exp_q.push_back({5'd11, 32'h0000_0000});
        send(mk_op(OP_LW, 32'hA00, 1'b1, 1'b1, 5'd11, 32'h0000_0A00));
        st   = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stallreq_for_dc) begin
                done = 1'b1;
            end else begin
                st++;
                @(posedge clk); #1;
            end
        end
        check("timeout_stall_cycles", 64'(st), 64'd16);
        check("timeout_flag",         64'(dc_load_timeout), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("timeout_sticky", 64'(dc_load_timeout), 64'd1);
        @(posedge clk); #1;
`else
        // without the watchdog a long wait simply keeps stalling
        exp_q.push_back({5'd11, 32'h0BAD_F00D});
        send(mk_op(OP_LW, 32'hA00, 1'b1, 1'b1, 5'd11, 32'h0000_0A00));
        load_resp(20, 32'h0BAD_F00D, st);
        check("long_wait_stalls", 64'(st), 64'd20);
        check("no_timeout_flag",  64'(dc_load_timeout), 64'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dc_load_stage.md
DC_LOAD_STAGE -- requirements
Module: dc_load_stage

Interface
REQ-001 SHALL have parameter EX_TO_DC_WD, 152, width of the incoming EX bus.
REQ-002 SHALL have parameter DC_TO_WB_WD, 136, width of the outgoing WB bus.
REQ-003 SHALL have parameter DC_TO_RF_WD, 105, width of the forwarding bus.
REQ-004 SHALL have parameter TIMEOUT_CYC, 16, load-wait watchdog limit (used only under DC_LOAD_TIMEOUT_EN).
REQ-005 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port stall  in  6  global stall vector; bit4 is this stage, bit5 is WB, 1 = Stop.
REQ-008 SHALL have port stallreq_for_dc  out  1  high while a registered load awaits its data.
REQ-009 SHALL have port ex_to_dc_bus  in  EX_TO_DC_WD  {is_load[151], mem_op[150:143] (lb,lbu,lh,lhu,lw,sb,sh,sw), hilo_bus[142:77], pc[76:45], ram_en[44], ram_wen[43], ram_sel[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-010 SHALL have port data_sram_rdata  in  32  load data word.
REQ-011 SHALL have port data_sram_rvalid  in  1  one-cycle pulse qualifying data_sram_rdata.
REQ-012 SHALL have port dc_to_wb_bus  out  DC_TO_WB_WD  {hilo_bus[135:70], pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-013 SHALL have port dc_to_rf_bus  out  DC_TO_RF_WD  {load_pending[104], hilo_bus[103:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-014 SHALL have port dc_load_timeout  out  1  sticky watchdog flag (tied 0 without DC_LOAD_TIMEOUT_EN).

Function
REQ-015 Pipeline register SHALL load ex_to_dc_bus when stall[4]=0; load all-zero bubble when stall[4]=1 and stall[5]=0; hold otherwise.
REQ-016 FSM SHALL have states IDLE, WAIT, DONE; IDLE when registered is_load=0.
REQ-017 Registered load with rvalid=0 SHALL enter/stay WAIT; rvalid=1 in IDLE or WAIT SHALL capture rdata into a 32-bit buffer and go to DONE.
REQ-018 rvalid in the same cycle the load becomes registered SHALL count (zero-wait load, no stall asserted).
REQ-019 stallreq_for_dc SHALL equal (is_load AND state!=DONE AND rvalid=0), combinationally.
REQ-020 DONE SHALL hold the buffer until the register advances or bubbles, then return to IDLE (or WAIT if a new load enters).
REQ-021 rvalid while no load is registered, or in DONE, SHALL be ignored.
REQ-022 Load data word SHALL be rvalid ? data_sram_rdata : buffer.
REQ-023 Alignment by ex_result[1:0]: lb sign-extends selected byte; lbu zero-extends; lh/lhu select half by ex_result[1] (ex_result[0] ignored); lw passes word.
REQ-024 rf_wdata SHALL be aligned load data when sel_rf_res=1, else ex_result.
REQ-025 load_pending SHALL equal stallreq_for_dc, so ID does not forward unready data.
REQ-026 Stores and non-memory ops SHALL pass through unchanged with zero added latency.

Reset
REQ-027 resetn low SHALL asynchronously clear pipeline register, buffer, FSM (IDLE), watchdog counter and dc_load_timeout; all outputs then 0.
REQ-028 Reset during WAIT SHALL abandon the load; a later stray rvalid SHALL be ignored.

Configuration
REQ-029 With DC_LOAD_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; reaching TIMEOUT_CYC SHALL set dc_load_timeout, capture 0x00000000 and go to DONE.
REQ-030 Without DC_LOAD_TIMEOUT_EN, no counter SHALL exist, WAIT is unbounded, dc_load_timeout=0.

Structure
REQ-031 Bus widths, stall indices, Stop/NoStop, and FSM encodings SHALL live in the shared defines package.
REQ-032 Alignment SHALL be sub-module load_align (mem_op, addr[1:0], word -> rf data), purely combinational.

Verification
REQ-033 lw @0x100, rvalid same cycle, rdata=0x12345678 -> no stall, rf_wdata=0x12345678 next stage.
REQ-034 lb addr[1:0]=3, rdata=0x80FF0000, rvalid after 3 cycles -> stall 3 cycles, rf_wdata=0xFFFFFF80; lbu -> 0x00000080.
REQ-035 lhu addr[1:0]=2, rdata=0xBEEF1234 -> 0x0000BEEF; lh -> 0xFFFFBEEF.
REQ-036 rvalid in DONE while stall[5]=1 for 4 cycles -> buffer unchanged, data emitted once stage advances.
REQ-037 resetn low mid-WAIT, stray rvalid after release -> IDLE, all outputs 0, no write.
REQ-038 With DC_LOAD_TIMEOUT_EN, no rvalid -> dc_load_timeout=1 after 16 cycles, stall drops, rf_wdata=0.
